// File: rtl/stream_burst_reader.sv
// Pop-side burst consumer for the 16-deep stream FIFO: pops fixed-length bursts
// once enough words are queued, and flushes a partial burst after an idle timeout.
//
// state  | meaning
// IDLE   | no pops; deciding whether to start a full or timed-out partial burst
// BURST  | popping words into the output register
// TAIL   | last word held in the output register, waiting for its handshake
module stream_burst_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int OCC_WIDTH     = 5,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     io_enable,
    input  logic [OCC_WIDTH-1:0]     io_burstLen,
    input  logic [TIMEOUT_WIDTH-1:0] io_timeout,
    input  logic                     fifo_valid,
    output logic                     fifo_ready,
    input  logic [DATA_WIDTH-1:0]    fifo_payload,
    input  logic [OCC_WIDTH-1:0]     fifo_occupancy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_payload,
    output logic                     out_last,
    output logic                     io_busy,
    output logic [15:0]              io_burstCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [OCC_WIDTH-1:0]     remaining_q, remaining_d;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]    out_payload_q, out_payload_d;
    logic [15:0]              burst_count_q, burst_count_d;

    logic                     pop;
    logic                     out_fire;
    logic                     start_full;
    logic                     start_timeout;
    logic                     occ_nonzero;
    logic [TIMEOUT_WIDTH-1:0] timeout_m1;

    assign fifo_ready = (state_q == ST_BURST) && (remaining_q != '0) && (!out_valid_q || out_ready);
    assign pop        = fifo_valid && fifo_ready;
    assign out_fire   = out_valid_q && out_ready;
    assign occ_nonzero = (fifo_occupancy != '0);
    assign timeout_m1 = io_timeout - TIMEOUT_WIDTH'(1);

    // Full bursts win; the timeout only flushes whatever is queued when no full burst is possible.
    assign start_full    = io_enable && (io_burstLen != '0) && (fifo_occupancy >= io_burstLen);
    assign start_timeout = io_enable && (io_timeout != '0) && occ_nonzero && (wait_cnt_q == timeout_m1);

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        wait_cnt_d    = '0;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_payload_d = out_payload_q;
        burst_count_d = burst_count_q;

        if (pop) begin
            out_payload_d = fifo_payload;
            out_valid_d   = 1'b1;
            out_last_d    = (remaining_q == OCC_WIDTH'(1));
            remaining_d   = remaining_q - OCC_WIDTH'(1);
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_full) begin
                    state_d     = ST_BURST;
                    remaining_d = io_burstLen;
                end else if (start_timeout) begin
                    state_d     = ST_BURST;
                    remaining_d = fifo_occupancy;
                end else if (io_enable && occ_nonzero) begin
                    wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            ST_BURST: begin
                if (pop && (remaining_q == OCC_WIDTH'(1))) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (out_fire && out_last_q) begin
                    state_d       = ST_IDLE;
                    burst_count_d = burst_count_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            wait_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_payload_q <= '0;
            burst_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            wait_cnt_q    <= wait_cnt_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_payload_q <= out_payload_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_payload   = out_payload_q;
    assign io_busy       = (state_q != ST_IDLE);
    assign io_burstCount = burst_count_q;

endmodule

// File: tb/tb_stream_burst_reader.sv
// Bench for stream_burst_reader: a queue-backed FIFO feeds the DUT and a burst-level
// reference model predicts busy, burst count, output words and last flags.
module tb_stream_burst_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        io_enable;
    logic [4:0]  io_burstLen;
    logic [7:0]  io_timeout;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [7:0]  fifo_payload;
    logic [4:0]  fifo_occupancy;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_payload;
    logic        out_last;
    logic        io_busy;
    logic [15:0] io_burstCount;

    always #5 clk = ~clk;

    stream_burst_reader dut (
        .clk            (clk),
        .resetn         (resetn),
        .io_enable      (io_enable),
        .io_burstLen    (io_burstLen),
        .io_timeout     (io_timeout),
        .fifo_valid     (fifo_valid),
        .fifo_ready     (fifo_ready),
        .fifo_payload   (fifo_payload),
        .fifo_occupancy (fifo_occupancy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_payload    (out_payload),
        .out_last       (out_last),
        .io_busy        (io_busy),
        .io_burstCount  (io_burstCount)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    bit          m_busy = 0;
    int          m_len = 0;
    int          m_done = 0;
    int          m_idle = 0;
    logic [15:0] m_count = '0;
    int          words_out = 0;
    int          stall_pct = 0;
    int          ready_mode = 0;
    bit          tog = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_pl = '0;
    logic        prev_last = 1'b0;
    bit          pop_now = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        if (fifo_q.size() < 16) begin
            fifo_q.push_back(v);
            exp_q.push_back(v);
        end
    endtask

    task automatic drive();
        int sz;
        sz = fifo_q.size();
        fifo_valid     = (sz != 0) && ($urandom_range(99) >= 32'(stall_pct));
        fifo_payload   = (sz != 0) ? fifo_q[0] : 8'h00;
        fifo_occupancy = 5'(sz);
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin tog = ~tog; out_ready = tog; end
            default: out_ready = ($urandom_range(99) < 60);
        endcase
    endtask

    // One clock: drive after the falling edge, sample and update the model, let the edge pass.
    task automatic cycle();
        int occ;
        bit was_busy;
        drive();
        #1;
        was_busy = m_busy;
        chk("busy", 32'(io_busy), 32'(m_busy));
        chk("count", 32'(io_burstCount), 32'(m_count));
        if (!was_busy) begin
            chk("rdy_idle", 32'(fifo_ready), 32'd0);
            chk("valid_idle", 32'(out_valid), 32'd0);
        end
        if (out_valid && !out_ready) chk("rdy_bp", 32'(fifo_ready), 32'd0);
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_payload), 32'(prev_pl));
            chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        prev_stall = out_valid && !out_ready;
        prev_pl    = out_payload;
        prev_last  = out_last;
        pop_now    = fifo_valid && fifo_ready;

        if (out_valid && out_ready && was_busy && exp_q.size() != 0) begin
            chk("data", 32'(out_payload), 32'(exp_q.pop_front()));
            chk("last", 32'(out_last), 32'(m_done + 1 == m_len));
            m_done++;
            words_out++;
            if (m_done == m_len) begin
                m_busy = 0;
                m_count++;
            end
        end

        if (!was_busy) begin
            occ = fifo_q.size();
            if (io_enable && io_burstLen != 0 && occ >= int'(io_burstLen)) begin
                m_busy = 1; m_len = int'(io_burstLen); m_done = 0; m_idle = 0;
            end else if (io_enable && io_timeout != 0 && occ != 0 && m_idle == int'(io_timeout) - 1) begin
                m_busy = 1; m_len = occ; m_done = 0; m_idle = 0;
            end else if (io_enable && occ != 0) begin
                m_idle = (m_idle < 255) ? m_idle + 1 : 255;
            end else begin
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end

        @(posedge clk);
        @(negedge clk);
        if (pop_now) void'(fifo_q.pop_front());
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_words(input int target, input int budget, input string tag);
        int b;
        b = 0;
        while (words_out < target && b < budget) begin
            cycle();
            b++;
        end
        chk(tag, 32'(words_out), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        resetn = 1'b0;
        io_enable = 1'b0; io_burstLen = '0; io_timeout = '0;
        drive();
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_payload", 32'(out_payload), 32'd0);
        chk("rst_busy", 32'(io_busy), 32'd0);
        chk("rst_count", 32'(io_burstCount), 32'd0);
        chk("rst_ready", 32'(fifo_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Full burst
        io_enable = 1'b1; io_burstLen = 5'd4; io_timeout = 8'd0;
        base = words_out;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        wait_words(base + 4, 30, "full_words");
        run(2);
        chk("full_count", 32'(io_burstCount), 32'd1);
        chk("full_idle", 32'(io_busy), 32'd0);

        // Backpressure with toggling ready
        ready_mode = 1; io_burstLen = 5'd3;
        base = words_out;
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        wait_words(base + 3, 40, "bp_words");
        run(2);
        chk("bp_count", 32'(io_burstCount), 32'd2);
        ready_mode = 0;

        // Timeout-triggered partial burst
        io_burstLen = 5'd8; io_timeout = 8'd5;
        base = words_out;
        push(8'h55); push(8'h66);
        wait_words(base + 2, 40, "to_words");
        run(2);
        chk("to_count", 32'(io_burstCount), 32'd3);

        // Timeout disabled: nothing until a full burst is available
        io_timeout = 8'd0;
        base = words_out;
        push(8'h70); push(8'h71);
        run(100);
        chk("to_off_quiet", 32'(words_out), 32'(base));
        for (int i = 0; i < 6; i++) push(8'h72 + 8'(i));
        wait_words(base + 8, 40, "to_off_words");
        run(2);

        // Enable and length gating, then a maximum-length burst
        io_enable = 1'b0;
        base = words_out;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        run(20);
        chk("gate_en", 32'(words_out), 32'(base));
        io_enable = 1'b1; io_burstLen = 5'd0;
        run(20);
        chk("gate_len", 32'(words_out), 32'(base));
        io_burstLen = 5'd16;
        wait_words(base + 16, 60, "len16_words");
        run(2);
        chk("len16_count", 32'(io_burstCount), 32'd5);

        // Reset in the middle of a burst
        io_burstLen = 5'd4; io_timeout = 8'd3;
        base = words_out;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        wait_words(base + 2, 30, "rst_mid_wait");
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(io_busy), 32'd0);
        chk("rst_mid_count", 32'(io_burstCount), 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        m_busy = 0; m_count = '0; m_idle = 0; m_done = 0; prev_stall = 0;
        exp_q = fifo_q;
        base = words_out + fifo_q.size();
        wait_words(base, 40, "rst_restart_words");
        run(2);
        chk("rst_restart_count", 32'(io_burstCount), 32'd1);

        // Randomized traffic with stalls and configuration changes
        stall_pct = 25; ready_mode = 2;
        for (int c = 0; c < 800; c++) begin
            if (c % 64 == 0) begin
                io_burstLen = 5'($urandom_range(16, 1));
                io_timeout  = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(12, 1));
                io_enable   = ($urandom_range(9) != 0);
            end
            if ($urandom_range(99) < 40) push(8'($urandom));
            cycle();
        end

        // Drain everything still queued
        io_enable = 1'b1; io_burstLen = 5'd16; io_timeout = 8'd2; stall_pct = 0; ready_mode = 0;
        for (int b = 0; b < 200 && (exp_q.size() != 0 || m_busy); b++) cycle();
        chk("drain_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
